density_phase_scheduler: RTL and testbench
==========================================

// Module: density_phase_scheduler
// PURPOSE
//  Sequences the four-way light datapath. Picks the side to serve from the per-side
//  traffic-present switches. Sets green length from density. Drives the SIDE/G/O
//  phase signals consumed by the light output decode. All sides are red whenever
//  G=O=0. Also returns the selected side's traffic flag and a seconds countdown
//  for the display.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per 1 s tick (>=2)
//  GREEN_LONG  30          green ticks when served side has traffic at green entry
//  GREEN_SHORT 10          green ticks when served side is empty at green entry
//  GREEN_MIN   5           min green ticks before early cut (< GREEN_SHORT)
//  ORANGE_T    3           orange ticks
//  ALLRED_T    1           all-red clearance ticks (>=1)
// PORTS
//  clk      in   1  system clock
//  rst      in   1  asynchronous reset, active-high
//  T        in   4  traffic present per side; bit i = side i; async switches, 2-flop synced
//  EMG_REQ  in   1  emergency preemption request, level; 2-flop synced
//  EMG_SIDE in   2  side to preempt to; sampled with EMG_REQ
//  SIDE     out  2  side currently served
//  G        out  1  green for SIDE
//  O        out  1  orange for SIDE
//  T_SEL    out  1  synced T[SIDE]
//  SEC_LEFT out  6  ticks remaining in current phase
// BEHAVIOUR
//  Reset: state=ALLRED, SIDE=0, G=0, O=0, SEC_LEFT=ALLRED_T, prescaler=0, sync flops=0.
//  Tick: one-cycle pulse when the prescaler wraps TICK_DIV-1 -> 0. The prescaler is free-running.
//   It is never cleared on a phase change.
//  Phase timer: loaded on phase entry; decremented on each tick. Phase exits on the tick
//   where timer==1, so every phase lasts exactly N tick pulses. SEC_LEFT = timer.
//  States / outputs, all registered:
//   ALLRED (G=0,O=0) -> GREEN (G=1,O=0) -> ORANGE (G=0,O=1) -> ALLRED.
//  ALLRED exit, side select (new SIDE and G=1 appear in the same cycle):
//   - EMG_REQ=1: SIDE <= EMG_SIDE.
//   - Else: round-robin from SIDE+1 (mod 4). Take the first side whose T bit is 1.
//   - If no T bit is set: SIDE+1.
//  GREEN load: GREEN_LONG if T[new SIDE]=1, else GREEN_SHORT.
//  GREEN early cut: go to ORANGE on the next clk when all of these hold:
//   - elapsed >= GREEN_MIN
//   - T[SIDE]=0
//   - some other T bit = 1
//   - EMG_REQ=0
//  EMG while GREEN, EMG_SIDE==SIDE: timer frozen at its current value; green held while
//   EMG_REQ=1. When EMG_REQ drops, the timer resumes.
//  EMG while GREEN, EMG_SIDE!=SIDE: go to ORANGE on the next clk, GREEN_MIN ignored.
//   Orange and all-red are never shortened.
//  EMG in ORANGE/ALLRED: no effect until the ALLRED exit select.
//  Simultaneous tick-expiry and early-cut/EMG in the same cycle: one ORANGE entry only.
//  Timer never underflows. G and O are never both 1. SIDE changes only at ALLRED->GREEN.
//  Reset mid-phase: asynchronous return to reset values; no orange is forced.
//  Latency: T/EMG input -> effect is 2 clk sync + 1 clk decision.
// STRUCTURE
//  traffic_defs.vh, shared include:
//   - state encodings ST_ALLRED=2'd0, ST_GREEN=2'd1, ST_ORANGE=2'd2
//   - side constants SIDE_N=0, SIDE_E=1, SIDE_S=2, SIDE_W=3
//  Sub-module tick_gen(clk,rst,tick), parameter TICK_DIV: the prescaler.
//  Top: synchronisers, phase FSM, round-robin selector (combinational), phase timer.
// TESTING
//  Use TICK_DIV=4, GREEN_LONG=6, GREEN_SHORT=3, GREEN_MIN=2, ORANGE_T=2, ALLRED_T=1.
//  1) Reset; T=4'b0000 -> SIDE cycles 1,2,3,0; each green 3 ticks (12 clk), orange 2, all-red 1.
//  2) T=4'b0100 after reset -> first green SIDE=2, G=1 for exactly 6 ticks, SEC_LEFT 6..1.
//  3) SIDE=2 green with T=4'b0100; at tick 3 set T=4'b1000 -> ORANGE 3 clk later
//     (2 sync + 1 decision); next SIDE=3.
//  4) GREEN on SIDE=1; EMG_REQ=1, EMG_SIDE=3 -> ORANGE 2 ticks, ALLRED 1 tick, then SIDE=3, G=1.
//  5) EMG_REQ=1, EMG_SIDE=SIDE during green for 20 ticks -> G stays 1, SEC_LEFT frozen.
//     Release EMG_REQ -> countdown resumes from the frozen value.
//  6) Assert rst mid-ORANGE -> same cycle: G=0, O=0, SIDE=0, SEC_LEFT=1.
//     Assertions throughout: G&O never 1; SIDE stable outside ALLRED->GREEN.

Source files
------------

// File: rtl/density_phase_scheduler_pkg.sv
// Shared types and helpers for the four-way phase scheduler.
// Phase encodings, side constants and the round-robin pick.
package density_phase_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_ORANGE = 2'd2
    } state_t;

    localparam logic [1:0] SIDE_N = 2'd0;

    // Scan from side+1 around to side itself; fall back to side+1.
    function automatic logic [1:0] rr_pick(
        input logic [1:0] side,
        input logic [3:0] t
    );
        logic [1:0] s;
        logic [1:0] pick;
        logic       found;
        pick  = side + 2'd1;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            s = side + 2'(i);
            if (!found && t[s]) begin
                pick  = s;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/density_phase_scheduler_if.sv
// Request/phase bundle between the scheduler and its surroundings.
// master drives switches and emergency, slave drives phase outputs.
interface density_phase_scheduler_if;
    logic [3:0] T;
    logic       EMG_REQ;
    logic [1:0] EMG_SIDE;
    logic [1:0] SIDE;
    logic       G;
    logic       O;
    logic       T_SEL;
    logic [5:0] SEC_LEFT;

    modport master (
        output T, EMG_REQ, EMG_SIDE,
        input  SIDE, G, O, T_SEL, SEC_LEFT
    );

    modport slave (
        input  T, EMG_REQ, EMG_SIDE,
        output SIDE, G, O, T_SEL, SEC_LEFT
    );
endinterface

// File: rtl/density_phase_scheduler_tick_gen.sv
// Free-running prescaler producing a one-cycle tick on wrap.
// Never cleared by phase changes, only by reset.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/density_phase_scheduler.sv
// Four-way light phase sequencer: side select, density-based green,
// early cut on demand elsewhere and emergency preemption.
module density_phase_scheduler
    import density_phase_scheduler_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_LONG  = 30,
    parameter int GREEN_SHORT = 10,
    parameter int GREEN_MIN   = 5,
    parameter int ORANGE_T    = 3,
    parameter int ALLRED_T    = 1
) (
    input logic clk,
    input logic rst,
    density_phase_scheduler_if.slave bus
);
    localparam logic [5:0] LD_LONG   = 6'(GREEN_LONG);
    localparam logic [5:0] LD_SHORT  = 6'(GREEN_SHORT);
    localparam logic [5:0] LD_MIN    = 6'(GREEN_MIN);
    localparam logic [5:0] LD_ORANGE = 6'(ORANGE_T);
    localparam logic [5:0] LD_ALLRED = 6'(ALLRED_T);

    logic       tick;
    logic [3:0] t_s1, t_s2;
    logic       emg_s1, emg_s2;
    logic [1:0] es_s1, es_s2;

    state_t     state;
    logic [1:0] side;
    logic       g, o;
    logic [5:0] timer;
    logic [5:0] elapsed;

    logic [1:0] new_side;
    logic       others_set;
    logic       early_cut;
    logic       emg_away;
    logic       emg_hold;
    logic       last;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_s1   <= '0;
            t_s2   <= '0;
            emg_s1 <= 1'b0;
            emg_s2 <= 1'b0;
            es_s1  <= '0;
            es_s2  <= '0;
        end else begin
            t_s1   <= bus.T;
            t_s2   <= t_s1;
            emg_s1 <= bus.EMG_REQ;
            emg_s2 <= emg_s1;
            es_s1  <= bus.EMG_SIDE;
            es_s2  <= es_s1;
        end
    end

    assign new_side   = emg_s2 ? es_s2 : rr_pick(side, t_s2);
    assign others_set = |(t_s2 & ~(4'b0001 << side));
    assign early_cut  = (elapsed >= LD_MIN) && !t_s2[side]
                        && others_set && !emg_s2;
    assign emg_away   = emg_s2 && (es_s2 != side);
    assign emg_hold   = emg_s2 && (es_s2 == side);
    assign last       = (timer <= 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ALLRED;
            side    <= SIDE_N;
            g       <= 1'b0;
            o       <= 1'b0;
            timer   <= LD_ALLRED;
            elapsed <= '0;
        end else begin
            unique case (state)
                ST_ALLRED: begin
                    if (tick) begin
                        if (last) begin
                            state   <= ST_GREEN;
                            side    <= new_side;
                            g       <= 1'b1;
                            timer   <= t_s2[new_side] ? LD_LONG : LD_SHORT;
                            elapsed <= '0;
                        end else begin
                            timer <= timer - 6'd1;
                        end
                    end
                end
                ST_GREEN: begin
                    // Cut/preempt outranks tick so a coincident expiry
                    // still produces a single orange entry.
                    if (emg_away || early_cut || (tick && !emg_hold && last)) begin
                        state <= ST_ORANGE;
                        g     <= 1'b0;
                        o     <= 1'b1;
                        timer <= LD_ORANGE;
                    end else if (tick && !emg_hold) begin
                        timer   <= timer - 6'd1;
                        elapsed <= elapsed + 6'd1;
                    end
                end
                ST_ORANGE: begin
                    if (tick) begin
                        if (last) begin
                            state <= ST_ALLRED;
                            o     <= 1'b0;
                            timer <= LD_ALLRED;
                        end else begin
                            timer <= timer - 6'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_ALLRED;
                    g     <= 1'b0;
                    o     <= 1'b0;
                    timer <= LD_ALLRED;
                end
            endcase
        end
    end

    assign bus.SIDE     = side;
    assign bus.G        = g;
    assign bus.O        = o;
    assign bus.T_SEL    = t_s2[side];
    assign bus.SEC_LEFT = timer;
endmodule

// File: tb/tb_density_phase_scheduler.sv
// Scoreboard bench: expected phase records (side, G, O, entry
// countdown, length in clk) are queued and checked on each phase change.
module tb_density_phase_scheduler;

    typedef struct packed {
        logic [1:0] side;
        logic       g;
        logic       o;
        logic [5:0] sec0;
        logic [7:0] len;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc;
    rec_t exp_q[$];

    density_phase_scheduler_if bus();

    density_phase_scheduler #(
        .TICK_DIV   (4),
        .GREEN_LONG (6),
        .GREEN_SHORT(3),
        .GREEN_MIN  (2),
        .ORANGE_T   (2),
        .ALLRED_T   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Phase-change monitor
    logic [1:0] m_side;
    logic       m_g, m_o;
    logic [5:0] m_sec;
    int         m_len = 0;
    rec_t       got, e;

    always @(negedge clk) begin
        if (rst) begin
            m_len = 0;
        end else if (m_len == 0) begin
            m_side = bus.SIDE; m_g = bus.G; m_o = bus.O;
            m_sec  = bus.SEC_LEFT;
            m_len  = 1;
        end else if ({bus.SIDE, bus.G, bus.O} != {m_side, m_g, m_o}) begin
            got = '{side: m_side, g: m_g, o: m_o, sec0: m_sec, len: 8'(m_len)};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL phase_extra got side=%0d g=%0d o=%0d sec0=%0d len=%0d",
                         got.side, got.g, got.o, got.sec0, got.len);
            end else begin
                e = exp_q.pop_front();
                if (got != e) begin
                    bad++;
                    $display("FAIL phase got side=%0d g=%0d o=%0d sec0=%0d len=%0d exp side=%0d g=%0d o=%0d sec0=%0d len=%0d",
                             got.side, got.g, got.o, got.sec0, got.len,
                             e.side, e.g, e.o, e.sec0, e.len);
                end
            end
            if ((bus.SIDE != m_side) && !(bus.G && !m_g && !m_o)) begin
                bad++;
                $display("FAIL side_stable got=%0d was=%0d", bus.SIDE, m_side);
            end
            m_side = bus.SIDE; m_g = bus.G; m_o = bus.O;
            m_sec  = bus.SEC_LEFT;
            m_len  = 1;
        end else begin
            m_len++;
        end
        if (bus.G && bus.O) begin
            bad++;
            $display("FAIL go_exclusive got G=1 O=1 exp not both");
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int g, input int o,
                        input int sec, input int len);
        exp_q.push_back('{side: 2'(s), g: 1'(g), o: 1'(o),
                          sec0: 6'(sec), len: 8'(len)});
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("leftover_records", exp_q.size(), 0);
        exp_q.delete();
        chk("rst_side", bus.SIDE, 0);
        chk("rst_g", bus.G, 0);
        chk("rst_o", bus.O, 0);
        chk("rst_sec", bus.SEC_LEFT, 1);
        #2 rst = 1'b0;
    endtask

    task automatic cycle_all(input int s);
        push(s, 1, 0, 3, 12);
        push(s, 0, 1, 2, 8);
        push(s, 0, 0, 1, 4);
    endtask

    initial begin
        bus.T = 4'b0000;
        bus.EMG_REQ = 1'b0;
        bus.EMG_SIDE = 2'd0;

        // Idle: round robin 1,2,3,0 on short greens
        do_reset();
        push(0, 0, 0, 1, 3);
        cycle_all(1);
        cycle_all(2);
        cycle_all(3);
        cycle_all(0);
        at_cyc(5);
        chk("idle_tsel", bus.T_SEL, 0);
        chk("idle_sec", bus.SEC_LEFT, 3);
        drain(200);

        // Traffic on side 2: long green
        bus.T = 4'b0100;
        do_reset();
        push(0, 0, 0, 1, 3);
        push(2, 1, 0, 6, 24);
        push(2, 0, 1, 2, 8);
        push(2, 0, 0, 1, 4);
        at_cyc(10);
        chk("long_tsel", bus.T_SEL, 1);
        chk("long_sec", bus.SEC_LEFT, 5);
        drain(100);

        // Early cut off-tick, then serve side 3
        bus.T = 4'b0100;
        do_reset();
        push(0, 0, 0, 1, 3);
        push(2, 1, 0, 6, 15);
        push(2, 0, 1, 2, 5);
        push(2, 0, 0, 1, 4);
        push(3, 1, 0, 6, 24);
        at_cyc(16);
        bus.T = 4'b1000;
        drain(200);

        // Early cut landing on a tick edge: one orange only
        bus.T = 4'b0100;
        do_reset();
        push(0, 0, 0, 1, 3);
        push(2, 1, 0, 6, 16);
        push(2, 0, 1, 2, 8);
        push(2, 0, 0, 1, 4);
        push(3, 1, 0, 6, 24);
        at_cyc(17);
        bus.T = 4'b1000;
        drain(200);

        // Emergency away from side 1, then hold on side 3
        bus.T = 4'b0000;
        bus.EMG_SIDE = 2'd3;
        do_reset();
        push(0, 0, 0, 1, 3);
        push(1, 1, 0, 3, 5);
        push(1, 0, 1, 2, 7);
        push(1, 0, 0, 1, 4);
        push(3, 1, 0, 3, 92);
        push(3, 0, 1, 2, 8);
        at_cyc(6);
        bus.EMG_REQ = 1'b1;
        at_cyc(60);
        chk("emg_hold_sec", bus.SEC_LEFT, 3);
        chk("emg_hold_g", bus.G, 1);
        chk("emg_hold_side", bus.SIDE, 3);
        at_cyc(100);
        bus.EMG_REQ = 1'b0;
        at_cyc(105);
        chk("emg_resume_sec", bus.SEC_LEFT, 2);
        drain(200);

        // Reset in the middle of orange
        bus.T = 4'b0000;
        do_reset();
        push(0, 0, 0, 1, 3);
        push(1, 1, 0, 3, 12);
        at_cyc(18);
        chk("pre_rst_o", bus.O, 1);
        chk("pre_rst_side", bus.SIDE, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_g", bus.G, 0);
        chk("async_rst_o", bus.O, 0);
        chk("async_rst_side", bus.SIDE, 0);
        chk("async_rst_sec", bus.SEC_LEFT, 1);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
